// File: rtl/adder_pkg.sv
// Shared constants and the requester weight helper for the add scheduler.
`timescale 1ns/1ps
package adder_pkg;

  localparam int unsigned N_REQ_DEF    = 3;
  localparam int unsigned MAX_DATA_DEF = 16;
  localparam int unsigned CLK_HZ       = 25_000_000;

  // Requester i contributes 1 << i to the accumulator.
  function automatic int unsigned weight(input int unsigned i);
    return 32'd1 << i;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request bit searching upward from ptr.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && pend[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/add_scheduler.sv
// Queues single-cycle increment requests and feeds them one per cycle into a shared
// accumulator, arbitrated round-robin.
`timescale 1ns/1ps
module add_scheduler
  import adder_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned MAX_DATA = MAX_DATA_DEF,
  parameter int unsigned WIDTH    = $clog2(MAX_DATA),
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [N_REQ-1:0] grant_o,
  output logic             busy_o,
  output logic             wrap_o,
  output logic             drop_o
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             wrap_q, wrap_d;
  logic             drop_q, drop_d;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             any;
  logic [WIDTH:0]   sum;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .pend      (pend_q),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign sum = {1'b0, acc_q} + (WIDTH+1)'(weight(32'(grant_idx)));

  always_comb begin
    acc_d  = acc_q;
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    // A granted requester that pulses again in the same cycle stays queued.
    pend_d = (pend_q & ~grant) | req_i;
    drop_d = |(req_i & pend_q & ~grant);
    if (any) begin
      wrap_d = sum[WIDTH];
      if (sum[WIDTH] && SATURATE) begin
        acc_d = '1;
      end else begin
        acc_d = sum[WIDTH-1:0];
      end
      ptr_d = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      pend_q <= '0;
      ptr_q  <= '0;
      wrap_q <= 1'b0;
      drop_q <= 1'b0;
    end else if (clr_i) begin
      acc_q  <= '0;
      pend_q <= '0;
      ptr_q  <= '0;
      wrap_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
      drop_q <= drop_d;
    end
  end

  assign acc_o   = acc_q;
  assign grant_o = grant;
  assign busy_o  = |pend_q;
  assign wrap_o  = wrap_q;
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_add_scheduler.sv
// Directed bench for add_scheduler: a wrapping and a saturating instance share stimulus.
`timescale 1ns/1ps
module tb_add_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [2:0] req;

  logic [3:0] acc, acc_s;
  logic [2:0] grant, grant_s;
  logic       busy, busy_s, wrap, wrap_s, drop, drop_s;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  add_scheduler #(.N_REQ(3), .MAX_DATA(16), .SATURATE(1'b0)) dut (
    .clk_25mhz (clk),
    .rst       (rst),
    .req_i     (req),
    .clr_i     (clr),
    .acc_o     (acc),
    .grant_o   (grant),
    .busy_o    (busy),
    .wrap_o    (wrap),
    .drop_o    (drop)
  );

  add_scheduler #(.N_REQ(3), .MAX_DATA(16), .SATURATE(1'b1)) dut_sat (
    .clk_25mhz (clk),
    .rst       (rst),
    .req_i     (req),
    .clr_i     (clr),
    .acc_o     (acc_s),
    .grant_o   (grant_s),
    .busy_o    (busy_s),
    .wrap_o    (wrap_s),
    .drop_o    (drop_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] m);
    req = m;
    tick();
    req = 3'b000;
    tick();
  endtask

  initial begin
    logic [3:0] exp_acc;
    logic [2:0] exp_gnt;
    rst = 1'b1;
    clr = 1'b0;
    req = 3'b000;
    tick();
    tick();
    check("rst_acc", 32'(acc), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_drop", 32'(drop), 0);
    #5 rst = 1'b0;
    tick();

    // All three requesters at once are served in order.
    req = 3'b111;
    tick();
    req = 3'b000;
    check("t1_grant0", 32'(grant), 32'b001);
    check("t1_busy", 32'(busy), 1);
    tick();
    check("t1_acc1", 32'(acc), 1);
    check("t1_grant1", 32'(grant), 32'b010);
    tick();
    check("t1_acc3", 32'(acc), 3);
    check("t1_grant2", 32'(grant), 32'b100);
    tick();
    check("t1_acc7", 32'(acc), 7);
    check("t1_idle", 32'(busy), 0);
    check("t1_gnt_idle", 32'(grant), 0);
    tick();
    check("steady_acc", 32'(acc), 7);
    check("steady_flags", 32'({wrap, drop}), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_acc", 32'(acc), 0);

    // Fairness under continuous requests from 0 and 1.
    req = 3'b011;
    exp_acc = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_gnt = (k % 2 == 1) ? 3'b001 : 3'b010;
      check("t2_grant", 32'(grant), 32'(exp_gnt));
      check("t2_acc", 32'(acc), 32'(exp_acc));
      exp_acc = exp_acc + ((k % 2 == 1) ? 4'd1 : 4'd2);
    end
    req = 3'b000;
    tick();
    check("t2_acc12", 32'(acc), 12);
    check("t2_grant_last", 32'(grant), 32'b001);
    tick();
    check("t2_acc13", 32'(acc), 13);
    check("t2_acc13_sat", 32'(acc_s), 13);
    check("t2_idle", 32'(busy), 0);

    // Overflow: wrap versus clamp.
    press(3'b001);
    check("t3_acc14", 32'(acc), 14);
    req = 3'b010;
    tick();
    req = 3'b000;
    check("t3_grant", 32'(grant), 32'b010);
    tick();
    check("t3_wrap_acc", 32'(acc), 0);
    check("t3_wrap_flag", 32'(wrap), 1);
    check("t3_sat_acc", 32'(acc_s), 15);
    check("t3_sat_flag", 32'(wrap_s), 1);
    tick();
    check("t3_wrap_pulse", 32'({wrap, wrap_s}), 0);
    check("t3_sat_hold", 32'(acc_s), 15);
    press(3'b001);
    check("t3_sat_acc2", 32'(acc_s), 15);
    check("t3_sat_flag2", 32'(wrap_s), 1);
    check("t3_wrap_acc2", 32'(acc), 1);
    check("t3_wrap_flag2", 32'(wrap), 0);

    // A repeated pulse on a still-pending requester is dropped.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    req = 3'b011;
    tick();
    req = 3'b010;
    check("t4_grant0", 32'(grant), 32'b001);
    tick();
    req = 3'b000;
    check("t4_drop", 32'(drop), 1);
    check("t4_acc1", 32'(acc), 1);
    check("t4_grant1", 32'(grant), 32'b010);
    tick();
    check("t4_acc3", 32'(acc), 3);
    check("t4_idle", 32'(busy), 0);
    check("t4_drop_pulse", 32'(drop), 0);

    // Clear beats pending work and a simultaneous request.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    press(3'b100);
    press(3'b100);
    press(3'b001);
    check("t5_acc9", 32'(acc), 9);
    req = 3'b101;
    tick();
    check("t5_busy", 32'(busy), 1);
    check("t5_grant", 32'(grant), 32'b100);
    clr = 1'b1;
    req = 3'b010;
    tick();
    clr = 1'b0;
    req = 3'b000;
    check("t5_acc", 32'(acc), 0);
    check("t5_busy0", 32'(busy), 0);
    check("t5_grant0", 32'(grant), 0);
    check("t5_wrap0", 32'(wrap), 0);
    tick();
    check("t5_discard", 32'({busy, acc}), 0);

    // Asynchronous reset between edges.
    press(3'b100);
    press(3'b001);
    check("t6_acc5", 32'(acc), 5);
    req = 3'b110;
    tick();
    req = 3'b000;
    check("t6_busy", 32'(busy), 1);
    #5 rst = 1'b1;
    #1;
    check("t6_async_acc", 32'(acc), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_grant", 32'(grant), 0);
    #5 rst = 1'b0;
    tick();
    check("t6_no_partial", 32'({busy, acc}), 0);
    press(3'b100);
    check("t6_acc4", 32'(acc), 4);
    check("t6_acc4_sat", 32'(acc_s), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
